// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
//   Unsigned 16x16 multiply-accumulate into a 36-bit wrapping accumulator.
//   Every rising edge of clk adds the full 32-bit product A*B to the
//   accumulator. The only exception is an edge with reset high, which clears
//   the accumulator. There is no enable, so a zero operand is how a caller
//   holds the value. The 4 guard bits above the product absorb 16
//   full-scale products before the sum wraps modulo 2^36.
//
// Ports (positional order is A, B, out, clk, reset)
//   A      in   16  unsigned multiplicand, sampled every rising edge
//   B      in   16  unsigned multiplier, sampled every rising edge
//   out    out  36  accumulator value, driven straight from the register
//   clk    in    1  clock, rising edge active
//   reset  in    1  synchronous active-high clear; wins over accumulation
// -----------------------------------------------------------------------------
module mac_unit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [35:0] out,
  input  logic        clk,
  input  logic        reset
);

  logic [31:0] w_product;
  logic [35:0] r_acc;

  // 32-bit assignment context keeps the full unsigned product.
  assign w_product = A * B;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else begin
      r_acc <= r_acc + {4'b0000, w_product};
    end
  end

  assign out = r_acc;

endmodule

// File: tb/tb_mac_unit.sv
module tb_mac_unit;

  logic [15:0] A;
  logic [15:0] B;
  logic [35:0] out;
  logic        clk;
  logic        reset;

  int checks = 0;
  int errors = 0;

  logic [35:0] m_acc;
  logic [35:0] sb_q[$];

  mac_unit dut (
    .A     (A),
    .B     (B),
    .out   (out),
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%09h expected 0x%09h", tag, obs, exp);
    end
  endtask

  // Drive one edge's worth of stimulus, push the expected result, then pop
  // it and compare once the DUT has produced its output.
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic r);
    logic [31:0] prod;
    logic [35:0] exp;
    @(negedge clk);
    A = a;
    B = b;
    reset = r;
    prod = 32'(a) * 32'(b);
    if (r) m_acc = '0;
    else   m_acc = m_acc + {4'b0000, prod};
    sb_q.push_back(m_acc);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = sb_q.pop_front();
      check(tag, out, exp);
    end
  endtask

  initial begin
    A = '0;
    B = '0;
    reset = 1'b0;
    m_acc = '0;

    // Reset with zero operands, then one idle edge.
    step("reset_zero", 16'd0, 16'd0, 1'b1);
    check("reset_const", out, 36'd0);
    step("idle_after_reset", 16'd0, 16'd0, 1'b0);
    check("idle_const", out, 36'd0);

    // Basic accumulation and hold.
    step("mac_12x20", 16'd12, 16'd20, 1'b0);
    check("mac_240", out, 36'd240);
    step("mac_11x5", 16'd11, 16'd5, 1'b0);
    check("mac_295", out, 36'd295);
    for (int i = 0; i < 5; i++) step("hold_zero", 16'd0, 16'd0, 1'b0);
    check("hold_295", out, 36'd295);
    step("a_zero", 16'd0, 16'd1234, 1'b0);
    step("b_zero", 16'd4321, 16'd0, 1'b0);
    check("zero_operand_295", out, 36'd295);

    // Full-scale products: 16 fit, the 17th wraps.
    step("reset_for_max", 16'd0, 16'd0, 1'b1);
    for (int i = 0; i < 16; i++) step("max_prod", 16'hFFFF, 16'hFFFF, 1'b0);
    check("max_16", out, 36'hFFFE00010);
    step("max_17", 16'hFFFF, 16'hFFFF, 1'b0);
    check("max_17_wrap", out, 36'h0FFDE0011);

    // Reset priority over a nonzero product, then resume.
    step("reset_again", 16'd0, 16'd0, 1'b1);
    step("mac_12x20_b", 16'd12, 16'd20, 1'b0);
    step("mac_11x5_b", 16'd11, 16'd5, 1'b0);
    check("pre_reset_295", out, 36'd295);
    step("reset_with_100x100", 16'd100, 16'd100, 1'b1);
    check("reset_priority", out, 36'd0);
    step("resume_100x100", 16'd100, 16'd100, 1'b0);
    check("resume_10000", out, 36'd10000);

    // Reset pulsed entirely between edges must not disturb out.
    step("pre_pulse", 16'd0, 16'd0, 1'b0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("pulse_between_edges", out, m_acc);
    @(posedge clk);
    #1;
    check("pulse_next_edge", out, 36'd10000);

    // Operand change between edges shows up only at the next edge.
    A = 16'd3;
    B = 16'd7;
    #2;
    check("ab_change_no_edge", out, 36'd10000);
    @(posedge clk);
    #1;
    m_acc = m_acc + 36'd21;
    check("ab_change_at_edge", out, 36'd10021);

    // Random operands against the model.
    for (int i = 0; i < 20; i++)
      step("random", 16'($urandom), 16'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_unit.md
MAC_UNIT -- requirements
Module: mac_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 A  input  16  unsigned multiplicand, sampled every rising edge.
REQ-005 B  input  16  unsigned multiplier, sampled every rising edge.
REQ-006 out  output  36  registered accumulator value (unsigned).
REQ-007 Positional port order SHALL be A, B, out, clk, reset, so that existing instantiations remain valid.

Function
REQ-008 The block SHALL hold one 36-bit accumulator register; out SHALL be driven directly from it, with no combinational path from A/B to out.
REQ-009 On each rising edge with reset=0, the block SHALL compute acc <= acc + (A * B), using the A and B values sampled at that edge.
REQ-010 The product SHALL be the full 32-bit unsigned product of A and B, zero-extended to 36 bits before the add.
REQ-011 Latency SHALL be one cycle: an A/B pair present at edge N SHALL be reflected in out immediately after edge N.
REQ-012 The accumulate operation SHALL occur every cycle, with no enable or handshake; A=0 or B=0 SHALL leave acc unchanged.
REQ-013 Overflow SHALL wrap modulo 2^36, with no saturation and no overflow flag; 16 maximum products (0xFFFE0001 each) SHALL fit without wrap.
REQ-014 All arithmetic SHALL be unsigned; no sign extension SHALL be applied to A, B, or the product.
REQ-015 The block SHALL contain no state besides the accumulator; out SHALL be stable between rising edges.
REQ-016 X/Z on A or B SHALL NOT be required to be handled; the inputs are assumed to be driven.

Reset
REQ-017 When reset=1 at a rising edge, acc SHALL become 0, regardless of A and B.
REQ-018 Reset SHALL take priority over accumulation at the same edge; the product at that edge SHALL be discarded.
REQ-019 Asserting reset mid-accumulation SHALL clear acc at the next edge; accumulation SHALL resume on the first edge with reset=0.
REQ-020 Reset SHALL be synchronous only; changing reset between edges SHALL NOT change out.
REQ-021 Before the first reset edge, out SHALL be treated as undefined; the bench SHALL assert reset before checking out.

Verification
REQ-022 Scenario: reset=1 for one edge with A=0, B=0 -> out=0; then reset=0 with A=0, B=0 for one edge -> out stays 0.
REQ-023 Scenario: after reset, A=12, B=20 for one edge -> out=240; then A=11, B=5 for one edge -> out=295; then A=0, B=0 for 5 edges -> out holds 295.
REQ-024 Scenario: A=0xFFFF, B=0xFFFF for 16 edges from 0 -> out=0xFFFE00010; the 17th edge wraps the result modulo 2^36.
REQ-025 Scenario: accumulate to 295, then assert reset=1 with A=100, B=100 for one edge -> out=0; deassert reset with A=100, B=100 -> out=10000.
REQ-026 Scenario: reset pulsed high and low entirely between two rising edges -> out unchanged.
REQ-027 Scenario: change A/B between edges -> out changes only at the next rising edge.
